// File: rtl/lfsr_prng_stream.sv
// Fibonacci LFSR word source: seed load with lock-up substitution, valid/ready
// output stream of the low OUT_W state bits, and an accepted-word counter.
module lfsr_prng_stream #(
  parameter int               WIDTH        = 64,
  parameter logic [WIDTH-1:0] TAPS         = 64'hD800_0000_0000_0000,
  parameter bit               XNOR_MODE    = 1'b1,
  parameter int               OUT_W        = 12,
  parameter int               STEPS        = 1,
  parameter logic [WIDTH-1:0] DEFAULT_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             seed_valid,
  input  logic [WIDTH-1:0] seed_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             seeded,
  output logic             seed_err,
  output logic [CNT_W-1:0] word_cnt
);

  localparam logic [WIDTH-1:0] LOCKUP = XNOR_MODE ? {WIDTH{1'b1}} : {WIDTH{1'b0}};

  typedef enum logic {IDLE, RUN} fsm_t;

  fsm_t             fsm_p0, fsm_nxt;
  logic [WIDTH-1:0] lfsr_p0;
  logic [CNT_W-1:0] cnt_p0;
  logic             seed_err_p0;

  logic [WIDTH-1:0] lfsr_adv;
  logic [WIDTH-1:0] seed_val;
  logic             seed_lockup;
  logic             accept;

  function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
    logic fb;
    fb = ^(s & TAPS);
    if (XNOR_MODE) fb = ~fb;
    return {s[WIDTH-2:0], fb};
  endfunction

  always_comb begin
    lfsr_adv = lfsr_p0;
    for (int i = 0; i < STEPS; i++) lfsr_adv = lfsr_step(lfsr_adv);
  end

  assign seed_lockup = (seed_data == LOCKUP);
  assign seed_val    = seed_lockup ? DEFAULT_SEED : seed_data;

  // Seed loads win over a handshake in the same cycle, so the stream stalls
  // for that cycle and the fresh seed is presented as the next word.
  assign seeded    = (fsm_p0 == RUN);
  assign out_valid = seeded & en & ~seed_valid;
  assign accept    = out_valid & out_ready;
  assign out_data  = lfsr_p0[OUT_W-1:0];
  assign seed_err  = seed_err_p0;
  assign word_cnt  = cnt_p0;

  always_comb begin
    fsm_nxt = fsm_p0;
    if (seed_valid) fsm_nxt = RUN;
  end

  // Stage p0: LFSR state, word counter and FSM state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fsm_p0      <= IDLE;
      lfsr_p0     <= '0;
      cnt_p0      <= '0;
      seed_err_p0 <= 1'b0;
    end else begin
      fsm_p0      <= fsm_nxt;
      seed_err_p0 <= seed_valid & seed_lockup;
      if (seed_valid) begin
        lfsr_p0 <= seed_val;
        cnt_p0  <= '0;
      end else if (accept) begin
        lfsr_p0 <= lfsr_adv;
        cnt_p0  <= cnt_p0 + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_lfsr_prng_stream.sv
// Bench for lfsr_prng_stream: three configurations driven by one shared
// stimulus stream, each tracked by a bit-history LFSR model.
module tb_lfsr_prng_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        seed_valid;
  logic        out_ready;
  logic [63:0] seed_data;

  logic [11:0] d0, d2;
  logic [3:0]  d1;
  logic [31:0] c0, c1, c2;
  logic [2:0]  o_valid, o_err, o_seeded;
  logic [63:0] o_data[3];
  logic [31:0] o_cnt[3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lfsr_prng_stream u_def (
    .clk(clk), .rst(rst), .en(en), .seed_valid(seed_valid), .seed_data(seed_data),
    .out_valid(o_valid[0]), .out_ready(out_ready), .out_data(d0),
    .seeded(o_seeded[0]), .seed_err(o_err[0]), .word_cnt(c0)
  );

  lfsr_prng_stream #(
    .WIDTH(4), .TAPS(4'b1100), .XNOR_MODE(1'b0), .OUT_W(4), .STEPS(1), .DEFAULT_SEED(4'h1)
  ) u_small (
    .clk(clk), .rst(rst), .en(en), .seed_valid(seed_valid), .seed_data(seed_data[3:0]),
    .out_valid(o_valid[1]), .out_ready(out_ready), .out_data(d1),
    .seeded(o_seeded[1]), .seed_err(o_err[1]), .word_cnt(c1)
  );

  lfsr_prng_stream #(.STEPS(12), .OUT_W(12)) u_st12 (
    .clk(clk), .rst(rst), .en(en), .seed_valid(seed_valid), .seed_data(seed_data),
    .out_valid(o_valid[2]), .out_ready(out_ready), .out_data(d2),
    .seeded(o_seeded[2]), .seed_err(o_err[2]), .word_cnt(c2)
  );

  assign o_data[0] = {52'b0, d0};
  assign o_data[1] = {60'b0, d1};
  assign o_data[2] = {52'b0, d2};
  assign o_cnt[0]  = c0;
  assign o_cnt[1]  = c1;
  assign o_cnt[2]  = c2;

  // Per-instance configuration seen by the model
  int          cfg_w[3]     = '{64, 4, 64};
  logic [63:0] cfg_taps[3]  = '{64'hD800_0000_0000_0000, 64'hC, 64'hD800_0000_0000_0000};
  bit          cfg_xnor[3]  = '{1'b1, 1'b0, 1'b1};
  int          cfg_steps[3] = '{1, 1, 12};
  int          cfg_ow[3]    = '{12, 4, 12};
  logic [63:0] cfg_def[3]   = '{64'h1, 64'h1, 64'h1};

  logic [63:0] m_state[3];
  logic [31:0] m_cnt[3];
  logic        m_seeded[3];
  logic        m_err[3];

  function automatic logic [63:0] wmask(input int w);
    return (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
  endfunction

  // The state is the last W bits of the generated bit history; each new bit is
  // the parity of the tapped history bits, inverted in XNOR mode.
  function automatic logic [63:0] m_next(input int i, input logic [63:0] s);
    logic fb;
    fb = ((($countones(s & cfg_taps[i]) % 2) == 1) ? 1'b1 : 1'b0) ^ cfg_xnor[i];
    return ((s << 1) | {63'b0, fb}) & wmask(cfg_w[i]);
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      m_state[i]  = '0;
      m_cnt[i]    = '0;
      m_seeded[i] = 1'b0;
      m_err[i]    = 1'b0;
    end
  endtask

  task automatic model_edge();
    logic [63:0] s, lock, mk;
    if (!rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      mk = wmask(cfg_w[i]);
      if (seed_valid) begin
        s    = seed_data & mk;
        lock = cfg_xnor[i] ? mk : 64'h0;
        m_err[i]    = (s == lock);
        m_state[i]  = (s == lock) ? cfg_def[i] : s;
        m_cnt[i]    = '0;
        m_seeded[i] = 1'b1;
      end else begin
        m_err[i] = 1'b0;
        if (m_seeded[i] && en && out_ready) begin
          for (int k = 0; k < cfg_steps[i]; k++) m_state[i] = m_next(i, m_state[i]);
          m_cnt[i] = m_cnt[i] + 32'd1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic ev;
    for (int i = 0; i < 3; i++) begin
      ev = rst & m_seeded[i] & en & ~seed_valid;
      check($sformatf("valid%0d", i),  {63'b0, o_valid[i]},  {63'b0, ev});
      check($sformatf("data%0d", i),   o_data[i], m_state[i] & wmask(cfg_ow[i]));
      check($sformatf("cnt%0d", i),    {32'b0, o_cnt[i]},    {32'b0, m_cnt[i]});
      check($sformatf("err%0d", i),    {63'b0, o_err[i]},    {63'b0, m_err[i]});
      check($sformatf("seeded%0d", i), {63'b0, o_seeded[i]}, {63'b0, m_seeded[i]});
    end
  endtask

  task automatic sample();
    #1;
    check_all();
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  logic [11:0] exp1[4] = '{12'h001, 12'h003, 12'h007, 12'h00F};
  logic [15:0] seen;
  logic [11:0] hold_d;
  logic [31:0] hold_c;

  initial begin
    rst = 1'b0; en = 1'b0; seed_valid = 1'b0; out_ready = 1'b0; seed_data = '0;
    model_reset();
    @(negedge clk);
    sample();
    check("rst_valid", {63'b0, o_valid[0]}, 64'd0);
    tick();
    rst = 1'b1;
    sample();
    tick();

    // Seed 1 on all instances, free-running stream
    seed_valid = 1'b1; seed_data = 64'h1; en = 1'b1; out_ready = 1'b1;
    sample();
    tick();
    seed_valid = 1'b0;
    seen = '0;
    for (int k = 0; k < 16; k++) begin
      sample();
      if (k < 4) begin
        check("t1_data", {52'b0, d0}, {52'b0, exp1[k]});
        check("t1_cnt", {32'b0, c0}, k);
      end
      if (k == 1) check("t5_word2", {52'b0, d2}, 64'hFFF);
      if (k < 15) begin
        check("t3_new_nonzero", {63'b0, (seen[d1] || d1 == 4'h0)}, 64'd0);
        seen[d1] = 1'b1;
      end else begin
        check("t3_period", {60'b0, d1}, 64'h1);
      end
      tick();
    end

    // Lock-up substitution: all-ones (XNOR instances), zero (XOR instance)
    seed_valid = 1'b1; seed_data = {64{1'b1}};
    sample();
    tick();
    seed_valid = 1'b0;
    sample();
    check("t2_err", {63'b0, o_err[0]}, 64'd1);
    check("t2_default", {52'b0, d0}, 64'h1);
    tick();
    sample();
    check("t2_err_clr", {63'b0, o_err[0]}, 64'd0);
    check("t2_next", {52'b0, d0}, 64'h3);
    tick();
    seed_valid = 1'b1; seed_data = 64'h0;
    sample();
    tick();
    seed_valid = 1'b0;
    sample();
    check("t2_xor_err", {63'b0, o_err[1]}, 64'd1);
    check("t2_xor_default", {60'b0, d1}, 64'h1);
    check("t2_xnor_zero_ok", {63'b0, o_err[0]}, 64'd0);
    tick();

    // Backpressure and enable stalls
    seed_valid = 1'b1; seed_data = 64'h5A5;
    sample(); tick();
    seed_valid = 1'b0;
    repeat (3) begin sample(); tick(); end
    out_ready = 1'b0;
    sample();
    hold_d = d0; hold_c = c0;
    tick();
    repeat (5) begin
      sample();
      check("t4_hold_data", {52'b0, d0}, {52'b0, hold_d});
      check("t4_hold_cnt", {32'b0, c0}, {32'b0, hold_c});
      tick();
    end
    out_ready = 1'b1;
    repeat (2) begin sample(); tick(); end
    en = 1'b0;
    sample();
    hold_d = d0; hold_c = c0;
    check("t4_en_valid", {63'b0, o_valid[0]}, 64'd0);
    tick();
    repeat (3) begin
      sample();
      check("t4_en_hold", {52'b0, d0}, {52'b0, hold_d});
      check("t4_en_cnt", {32'b0, c0}, {32'b0, hold_c});
      tick();
    end
    en = 1'b1;

    // Seed load concurrent with ready
    repeat (2) begin sample(); tick(); end
    seed_valid = 1'b1; seed_data = 64'hABC; out_ready = 1'b1;
    sample(); tick();
    seed_valid = 1'b0;
    sample();
    check("t6_cnt", {32'b0, c0}, 64'd0);
    check("t6_data", {52'b0, d0}, 64'hABC);
    tick();

    // Asynchronous reset mid-stream
    repeat (2) begin sample(); tick(); end
    sample();
    #2;
    rst = 1'b0;
    #1;
    check("t6_rst_valid", {63'b0, o_valid[0]}, 64'd0);
    check("t6_rst_seeded", {63'b0, o_seeded[0]}, 64'd0);
    model_reset();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    rst = 1'b1;
    repeat (3) begin
      sample();
      check("t6_idle", {63'b0, o_valid[0]}, 64'd0);
      tick();
    end

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      seed_valid = ($urandom % 20) == 0;
      case ($urandom % 4)
        0: seed_data = {64{1'b1}};
        1: seed_data = 64'h0;
        2: seed_data = 64'hF;
        default: seed_data = {$urandom, $urandom};
      endcase
      en        = ($urandom % 8) != 0;
      out_ready = ($urandom % 4) != 0;
      if (($urandom % 150) == 0) begin
        rst = 1'b0;
        model_reset();
      end else begin
        rst = 1'b1;
      end
      sample();
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
